// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory line port between the icache and
// dcache miss paths. One transaction in flight at a time, with a watchdog on mem_ack.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ready,
    output logic [LINE_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_ready,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              mem_err,
    output logic              busy
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, MEM, RESP_IC, RESP_DC} state_t;

    state_t           state, state_nxt;
    logic             last_dc;   // last grant went to the dcache
    logic             owner_dc;  // current transaction belongs to the dcache
    logic [CNT_W-1:0] cnt;
    logic             grant_dc, grant_ic, grant, timeout;

    // dcache wins a tie unless it was served last
    assign grant_dc = dc_req && (!ic_req || !last_dc);
    assign grant_ic = ic_req && !grant_dc;
    assign grant    = grant_dc || grant_ic;
    assign timeout  = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = MEM;
            MEM:     if (mem_ack || timeout) state_nxt = owner_dc ? RESP_DC : RESP_IC;
            RESP_IC: state_nxt = IDLE;
            RESP_DC: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_err   <= 1'b0;
            ic_rdata  <= '0;
            dc_rdata  <= '0;
            last_dc   <= 1'b0;
            owner_dc  <= 1'b0;
            cnt       <= '0;
        end else begin
            mem_err <= 1'b0;
            case (state)
                IDLE: if (grant) begin
                    mem_req   <= 1'b1;
                    mem_addr  <= grant_dc ? dc_addr : ic_addr;
                    mem_we    <= grant_dc && dc_we;
                    mem_wdata <= grant_dc ? dc_wdata : '0;
                    owner_dc  <= grant_dc;
                    last_dc   <= grant_dc;
                    cnt       <= '0;
                end
                MEM: begin
                    cnt <= cnt + 1'b1;
                    // ack beats a simultaneous timeout
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (owner_dc) dc_rdata <= mem_rdata;
                        else          ic_rdata <= mem_rdata;
                    end else if (timeout) begin
                        mem_req <= 1'b0;
                        mem_err <= 1'b1;
                        if (owner_dc) dc_rdata <= '0;
                        else          ic_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ic_ready = (state == RESP_IC);
    assign dc_ready = (state == RESP_DC);
    assign busy     = (state != IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares a single main-memory line port between the instruction-cache and data-cache miss paths.
- Accepts one outstanding request at a time, chooses between requesters round-robin, and sequences the memory handshake.
- Returns the line to the winning requester with a one-cycle ready pulse.
- Includes a watchdog so a missing memory acknowledge cannot hang the pipeline stalls.

Parameters:
- ADDR_W, 32, width of request and memory address.
- LINE_W, 128, width of a cache line transferred per transaction.
- TIMEOUT, 255, maximum number of cycles mem_req is held waiting for mem_ack before the transaction is aborted; must be at least 1.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- ic_req  in  1  icache miss request; level, held until ic_ready.
- ic_addr  in  ADDR_W  icache line address.
- ic_ready  out  1  one-cycle pulse: transaction done, ic_rdata valid.
- ic_rdata  out  LINE_W  line returned to icache; registered.
- dc_req  in  1  dcache request; level, held until dc_ready.
- dc_we  in  1  1 = line write-back, 0 = line fill.
- dc_addr  in  ADDR_W  dcache line address.
- dc_wdata  in  LINE_W  write-back data.
- dc_ready  out  1  one-cycle pulse: transaction done, dc_rdata valid.
- dc_rdata  out  LINE_W  line returned to dcache; registered.
- mem_req  out  1  memory request, held until mem_ack or timeout.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  LINE_W  memory write data.
- mem_ack  in  1  one-cycle memory completion; mem_rdata valid with it.
- mem_rdata  in  LINE_W  memory read data.
- mem_err  out  1  one-cycle pulse, coincident with the ready pulse, when the transaction timed out.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - all outputs 0, rdata registers 0;
  - state IDLE; last_grant = IC, so dcache wins the first tie;
  - timeout counter 0.
- Reset asserted mid-transaction aborts it immediately: no ready pulse is issued, and the next cycle has mem_req=0.
- States: IDLE, MEM, RESP_IC, RESP_DC.
- IDLE:
  - Samples requests each edge.
  - Only one request pending: grant it.
  - Both pending: grant the one not equal to last_grant (round-robin).
  - On grant, in the same edge: latch addr/we/wdata into the mem_* registers (icache grant forces we=0, wdata=0); set mem_req=1; record the owner; update last_grant; clear the counter; go to MEM.
- MEM:
  - mem_req, mem_addr, mem_we and mem_wdata are held stable.
  - The counter increments each cycle.
  - On mem_ack: mem_req=0; owner's rdata <= mem_rdata (for a write, rdata <= mem_rdata as driven, don't-care); go to the owner's RESP state.
  - If the counter reaches TIMEOUT without mem_ack: mem_req=0; owner's rdata <= 0; mem_err=1 registered for the RESP cycle; go to the owner's RESP state.
  - mem_ack and timeout in the same cycle: mem_ack wins, no error.
- RESP_IC / RESP_DC:
  - The owner's ready=1 for exactly this one cycle, then IDLE.
  - Requests are not sampled in RESP. The requester drops req at the edge ending RESP, so a stale req is never re-granted.
- Latency:
  - Request sampled at edge N → mem_req high from cycle N+1.
  - mem_ack in cycle M → ready high in cycle M+1, IDLE in M+2.
  - Minimum request-to-ready is 2 cycles.
- Back-to-back: a request still pending in the IDLE cycle after RESP is granted then. The other requester, if waiting, is favoured by round-robin.
- mem_ack in IDLE or RESP is ignored.
- A requester dropping req during MEM does not cancel the transaction; the ready pulse is still issued.
- mem_* outputs keep their last values in IDLE, except mem_req=0.
- The ready outputs are never high simultaneously.

Test Plan:
1. Reset then icache only: ic_req=1, ic_addr=0x100; mem_ack in the 3rd MEM cycle with mem_rdata=0xA5..A5 → mem_req high 3 cycles, mem_addr=0x100, mem_we=0; ic_ready pulses one cycle later with ic_rdata=0xA5..A5; dc_ready stays 0.
2. Simultaneous ic_req and dc_req right after reset, both held → dcache granted first; icache granted in the IDLE after dc_ready; mem_addr sequence dc_addr then ic_addr.
3. Dcache write-back: dc_we=1, dc_addr=0x2000, dc_wdata=0x1234 → mem_we=1, mem_wdata=0x1234 stable until mem_ack; dc_ready one pulse.
4. Zero-wait memory: mem_ack high the same cycle mem_req first rises → ready exactly 2 cycles after the req-sampling edge; busy high for those 2 cycles.
5. Timeout with TIMEOUT=4 and mem_ack never asserted → mem_req drops after 4 cycles; ic_ready and mem_err pulse together; ic_rdata=0; next request proceeds normally.
6. Reset asserted during MEM → next cycle mem_req=0, busy=0, no ready pulse; a new dc_req after reset is granted first (last_grant=IC).
